// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter, STEP bits per clock, start/done handshake.
// Optional ITERATIVE_SHIFTER_EARLY_EXIT_EN finishes as soon as the value saturates.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [CW-1:0]    rem;
  logic             busy_q;
  logic             done_q;

  logic [CW-1:0]    amt;
  logic [CW-1:0]    s;
  logic [CW-1:0]    rem_nx;
  logic [WIDTH-1:0] nw;
  logic             sat_acc;
  logic             sat_nw;

  function automatic logic [WIDTH-1:0] shift1(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       o
  );
    case (o)
      2'b00:   return {v[WIDTH-2:0], 1'b0};
      2'b01:   return {1'b0, v[WIDTH-1:1]};
      2'b10:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
  function automatic logic sat(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       o
  );
    case (o)
      2'b00,
      2'b01:   return v == '0;
      2'b10:   return (v == '0) || (v == '1);
      default: return 1'b0;
    endcase
  endfunction
`endif

  // effective shift amount: shamt mod WIDTH
  always_comb begin
    amt = '0;
    for (int i = 0; i < LW; i++) begin
      if (i < SHAMT_W) amt[i] = shamt[i];
    end
  end

  // this cycle's step: min(STEP, remaining), applied one bit at a time
  always_comb begin
    s      = (rem > CW'(STEP)) ? CW'(STEP) : rem;
    rem_nx = rem - s;
    nw     = work;
    for (int i = 0; i < STEP; i++) begin
      if (CW'(i) < s) nw = shift1(nw, op_q);
    end
  end

  // saturation detect on the incoming operand and the next working value
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
  always_comb begin
    sat_acc = sat(operand, op);
    sat_nw  = sat(nw, op_q);
  end
`else
  always_comb begin
    sat_acc = 1'b0;
    sat_nw  = 1'b0;
  end
`endif

  // control FSM with registered busy/done and working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      op_q   <= 2'b00;
      rem    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work   <= operand;
            op_q   <= op;
            rem    <= amt;
            busy_q <= 1'b1;
            if ((amt == '0) || sat_acc) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= nw;
          rem  <= rem_nx;
          if ((rem_nx == '0) || sat_nw) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          rem    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work;

endmodule

// File: tb/tb_iterative_shifter.sv
// Randomised + directed bench for iterative_shifter (STEP=1 and STEP=4).
// Expected result/latency come from an arithmetic model of the shift ops.
module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand = '0;
  logic [4:0]  shamt = '0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op),
    .operand(operand), .shamt(shamt),
    .busy(busy1), .done(done1), .result(result1)
  );

  iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op),
    .operand(operand), .shamt(shamt),
    .busy(busy4), .done(done4), .result(result4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x,
                                            input logic [1:0] o,
                                            input int a);
    case (o)
      2'b00:   return x << a;
      2'b01:   return x >> a;
      2'b10:   return $signed(x) >>> a;
      default: return (a == 0) ? x : ((x >> a) | (x << (32 - a)));
    endcase
  endfunction

  function automatic bit is_sat(input logic [31:0] v, input logic [1:0] o);
    if (o == 2'b11) return 1'b0;
    if (o == 2'b10) return (v == 32'h0) || (v == 32'hFFFF_FFFF);
    return v == 32'h0;
  endfunction

  function automatic int exp_lat(input int step, input logic [31:0] x,
                                 input logic [1:0] o, input int a);
    int moved;
    int cyc;
    if (a == 0) return 1;
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
    if (is_sat(x, o)) return 1;
`endif
    moved = 0;
    cyc = 0;
    while (moved < a) begin
      moved += ((a - moved) < step) ? (a - moved) : step;
      cyc++;
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
      if (is_sat(ref_shift(x, o, moved), o)) break;
`endif
    end
    return cyc + 1;
  endfunction

  task automatic set_start(input int st, input logic v);
    if (st == 1) start1 = v;
    else start4 = v;
  endtask

  task automatic sample(input int st, output logic b, output logic d,
                        output logic [31:0] r);
    if (st == 1) begin
      b = busy1; d = done1; r = result1;
    end else begin
      b = busy4; d = done4; r = result4;
    end
  endtask

  // Called at a negedge with the chosen instance idle; returns at the
  // negedge of the cycle after done (instance idle again).
  task automatic run(input int st, input logic [1:0] o, input logic [31:0] x,
                     input logic [4:0] sh, input int poke, input string tag);
    int a;
    int step;
    int lat;
    int cyc;
    logic b, d;
    logic [31:0] r;
    logic [31:0] exp_r;
    int exp_l;
    logic busy_ok;
    step = (st == 1) ? 1 : 4;
    a = int'(sh) % 32;
    exp_r = ref_shift(x, o, a);
    exp_l = exp_lat(step, x, o, a);
    op = o; operand = x; shamt = sh;
    set_start(st, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(st, 1'b0);
    op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
    lat = -1;
    busy_ok = 1'b1;
    cyc = 1;
    while (cyc <= 100) begin
      sample(st, b, d, r);
      set_start(st, cyc == poke);
      if (d) begin
        lat = cyc;
        if (!b) busy_ok = 1'b0;
        break;
      end
      if (!b) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    set_start(st, 1'b0);
    chk({tag, " latency"}, lat, exp_l);
    chk({tag, " result"}, r, exp_r);
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    sample(st, b, d, r);
    chk({tag, " done_after"}, {31'd0, d}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, b}, 32'd0);
    chk({tag, " hold"}, r, exp_r);
  endtask

  initial begin
    logic b, d;
    logic [31:0] r;
    int cnt;
    logic [31:0] x;

    #12;
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst done1", {31'd0, done1}, 32'd0);
    chk("rst result1", result1, 32'd0);
    chk("rst busy4", {31'd0, busy4}, 32'd0);
    chk("rst result4", result4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1, 2'b00, 32'h0000_0001, 5'd31, 0, "sll31");
    run(1, 2'b10, 32'h8000_0000, 5'd4, 0, "sra4");
    run(1, 2'b01, 32'h8000_0000, 5'd4, 0, "srl4");
    run(4, 2'b11, 32'h0000_00F0, 5'd8, 0, "ror8_s4");
    run(4, 2'b00, 32'h1234_5678, 5'd0, 0, "zero_s4");
    run(1, 2'b11, 32'h1234_5678, 5'd0, 0, "zero_s1");
    run(4, 2'b10, 32'h9000_0001, 5'd7, 0, "sra7_s4");

    run(1, 2'b00, 32'h0000_0003, 5'd10, 2, "busy_start");
    run(1, 2'b01, 32'hF000_0000, 5'd3, 0, "after_busy");

    op = 2'b00; operand = 32'h0000_0001; shamt = 5'd20;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy1}, 32'd0);
    chk("abort done", {31'd0, done1}, 32'd0);
    chk("abort result", result1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || busy1) cnt++;
    end
    chk("abort no_done", cnt, 0);
    run(1, 2'b00, 32'h0000_0001, 5'd20, 0, "fresh");

    run(1, 2'b01, 32'h0000_0010, 5'd20, 0, "ee_srl");
    run(1, 2'b10, 32'hFFFF_FFFF, 5'd9, 0, "ee_sra");
    run(4, 2'b00, 32'h0000_0000, 5'd17, 0, "ee_sll0");

    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      if ((i % 7) == 3) x = 32'h0;
      if ((i % 7) == 5) x = 32'hFFFF_FFFF;
      if ((i % 5) == 1) x = x >> $urandom_range(0, 31);
      run((i % 2 == 0) ? 1 : 4, 2'($urandom_range(0, 3)), x,
          5'($urandom_range(0, 31)), 0, "rand");
    end

    sample(1, b, d, r);
    chk("final idle", {31'd0, b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
